// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl
// Single-port register-array scratch memory with a built-in access/clear FSM.
// Write and read requests use a ready/valid handshake, and read data is
// registered. A bulk-clear sequence zeroes one word per cycle.
//
// Ports:
//   clk      system clock; all state changes on its rising edge
//   rst      synchronous reset, active-high
//   select   access request strobe; taken only while ready=1
//   op       access type: 1 = write, 0 = read
//   adr      word address, captured with an accepted request
//   wdata    write data, captured with an accepted write
//   clr      bulk-clear request; taken only while ready=1, beats select
//   ready    block is idle and accepts a request this cycle
//   rdata    registered read data; holds until the next read completes
//   rvalid   one-cycle pulse when rdata has just been updated
//   busy_clr clear sequence in progress
//
// state | meaning
// IDLE  | ready for clr or an access request
// WRITE | commit the captured write data at the end of this cycle
// READ  | load rdata from the captured address and pulse rvalid
// CLEAR | zero mem[cnt] each cycle until the last word is zeroed

module mem_array_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic              op,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy_clr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr)         state_nxt = CLEAR;
        else if (select) state_nxt = op ? WRITE : READ;
      end
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = IDLE;
      CLEAR:   if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready    = (state == IDLE);
  assign busy_clr = (state == CLEAR);

  // Request capture; a clear in the same cycle drops the access.
  always_ff @(posedge clk) begin
    if (state == IDLE && !clr && select) begin
      adr_q   <= adr;
      wdata_q <= wdata;
    end
  end

  // Clear counter wraps to 0 naturally after the last word.
  always_ff @(posedge clk) begin
    if (rst)                        cnt <= '0;
    else if (state == IDLE && clr)  cnt <= '0;
    else if (state == CLEAR)        cnt <= cnt + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= (state == READ);
      if (state == READ) rdata <= mem[adr_q];
    end
  end

  // Array has no reset; a reset edge suppresses any pending write or
  // clear step so an aborted sequence leaves untouched words intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == WRITE)      mem[adr_q] <= wdata_q;
      else if (state == CLEAR) mem[cnt]   <= '0;
    end
  end

endmodule

// File: doc/mem_array_ctrl.md
Name: mem_array_ctrl

Overview:
Parametrised single-port register-array memory with an integrated control FSM. It replaces the fixed 8-word x 8-bit memory and its separate fsm/decoder/cell split with one block.
- Generic data width and address depth.
- Explicit ready/valid handshaking and a registered read response.
- Hardware bulk-clear sequence.
- Sits between the bus-side requester and downstream logic as the local scratch store.

Parameters:
DATA_W, 8, width of each stored word and of wdata/rdata
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (derived, not overridable)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
select  input  1  access request strobe
op  input  1  access type: 1 = write, 0 = read
adr  input  ADDR_W  word address, sampled with the accepted request
wdata  input  DATA_W  write data, sampled with an accepted write
clr  input  1  bulk-clear request
ready  output  1  block accepts a request this cycle
rdata  output  DATA_W  read data, registered
rvalid  output  1  one-cycle pulse, rdata updated this cycle
busy_clr  output  1  clear sequence in progress

Behaviour:
Reset (rst=1 at a clk edge):
- state <= IDLE; rdata <= 0; rvalid <= 0; clear counter <= 0.
- Array contents are not reset. They are undefined until written or cleared.
- rst dominates every other input.

Outputs:
- ready = (state==IDLE), combinational from state; ready=1 in the cycle after reset.
- busy_clr = (state==CLEAR).

FSM states: IDLE, WRITE, READ, CLEAR.

IDLE transitions, in priority order:
- clr=1 -> CLEAR, counter <= 0.
- else select=1 & op=1 -> WRITE, capture adr, wdata.
- else select=1 & op=0 -> READ, capture adr.
- else stay.

WRITE:
- mem[adr_q] <= wdata_q at the end of this cycle.
- -> IDLE.
- Write occupies exactly one non-ready cycle.

READ:
- rdata <= mem[adr_q]; rvalid <= 1; -> IDLE.
- Latency: request sampled at edge E0, rvalid=1 and rdata valid in the cycle after edge E1, which is two cycles after the request cycle.
- rvalid is high in the same cycle ready is high again, so back-to-back requests are allowed.
- rvalid deasserts the following cycle unless another READ completes.
- rdata holds its value until the next read completes.

CLEAR:
- mem[counter] <= 0 each cycle; counter increments.
- When counter == DEPTH-1, that word is written and the state goes to IDLE; counter wraps to 0.
- Duration is exactly DEPTH cycles with ready=0.

Boundary conditions:
- select while ready=0 is ignored and not queued; the requester must hold or re-issue.
- clr and select both high in IDLE: clear wins and the access is dropped.
- clr asserted outside IDLE is ignored; a clear never restarts mid-sequence.
- Read after write to the same address is back-to-back legal and returns the new data, because the write has committed before READ samples.
- Address is full-range; there is no out-of-range case because DEPTH = 2**ADDR_W.
- rst during CLEAR aborts the sequence. Words already zeroed stay zero; the remaining words keep their prior contents.
- rst during WRITE: the write is not committed.
- rst during READ: no rvalid pulse is produced.

Width rules:
- Data is stored and returned unmodified, with no truncation.
- Counter is ADDR_W bits wide.

Test Plan:
(All with DATA_W=8, ADDR_W=3.)
1. Reset then idle: rst=1 for 2 cycles, release -> ready=1, rvalid=0, rdata=0x00, busy_clr=0.
2. Write/read: write 0xA5 to adr 3, then read adr 3 -> ready low 1 cycle; rvalid pulses exactly 1 cycle, 2 cycles after the read request, with rdata=0xA5.
3. Back-to-back sweep: write adr k = 0x10+k for k=0..7, then read 7..0 -> each rdata=0x10+k; a new request is issued in every ready cycle with no lost requests.
4. Bulk clear: after test 3, pulse clr -> busy_clr=1 and ready=0 for exactly 8 cycles; subsequent reads of all 8 addresses return 0x00.
5. Priority/ignore: clr=1 and select=1 (write 0xFF, adr 2) in the same IDLE cycle -> clear runs and adr 2 reads 0x00. select asserted during CLEAR -> ignored, and mem is unchanged by it.
6. Reset mid-clear: fill all words with 0x55, start clr, assert rst at the 4th CLEAR cycle -> adr 0..2 read 0x00, adr 3..7 read 0x55, and state is IDLE.
